// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file write path.
//   - default data width / register count and the derived address width
//   - sequencer FSM state encoding
//   - request record {addr, data} at the default widths
package reg_file_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int NUM_REGS_DEF = 2;

   // Address width for n registers; never narrower than one bit.
   function automatic int addr_w_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int ADDR_W_DEF = addr_w_of(NUM_REGS_DEF);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_INIT = 1'b1
   } seq_state_t;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } reg_req_t;

endpackage

// File: rtl/reg_req_fifo.sv
// Synchronous request FIFO with occupancy count.
//   clock, reset_n : clock, async active-low reset
//   push, wdata    : write side (push ignored while full)
//   pop, rdata     : read side; rdata shows the head (pop ignored while empty)
//   count          : occupancy 0..DEPTH
//   full, empty    : occupancy flags
module reg_req_fifo #(
   parameter  int WIDTH = 17,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only entries below count are ever read.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/reg_file_wr_sequencer.sv
// Write-port driver for the register file.
//   clock, reset_n                      : clock, async active-low reset
//   req_valid_in/req_ready_out          : request handshake
//   req_addr_in, req_data_in            : request payload
//   init_start_in, init_value_in        : start pulse / fill value for init
//   busy_out                            : INIT active or requests pending
//   fifo_count_out                      : request FIFO occupancy
//   r_d_wen_out, r_d_waddr_out, d_out   : registered register-file write port
module reg_file_wr_sequencer
   import reg_file_pkg::*;
#(
   parameter  int DATA_W     = DATA_W_DEF,
   parameter  int NUM_REGS   = NUM_REGS_DEF,
   parameter  int ADDR_W     = addr_w_of(NUM_REGS),
   parameter  int FIFO_DEPTH = 4,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid_in,
   output logic              req_ready_out,
   input  logic [ADDR_W-1:0] req_addr_in,
   input  logic [DATA_W-1:0] req_data_in,
   input  logic              init_start_in,
   input  logic [DATA_W-1:0] init_value_in,
   output logic              busy_out,
   output logic [CNT_W-1:0]  fifo_count_out,
   output logic              r_d_wen_out,
   output logic [ADDR_W-1:0] r_d_waddr_out,
   output logic [DATA_W-1:0] d_out
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;

   localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

   seq_state_t        state;
   logic [ADDR_W-1:0] init_cnt;
   logic [DATA_W-1:0] init_val;
   req_t              head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;

   // Start pulse wins over a pending pop; INIT never pops.
   assign pop = (state == ST_IDLE) & ~init_start_in & ~fifo_empty;

   reg_req_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (req_valid_in),
      .wdata   ({req_addr_in, req_data_in}),
      .pop     (pop),
      .rdata   (head),
      .count   (fifo_count_out),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign req_ready_out = ~fifo_full;
   assign busy_out      = (state == ST_INIT) | ~fifo_empty;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         init_cnt      <= '0;
         init_val      <= '0;
         r_d_wen_out   <= 1'b0;
         r_d_waddr_out <= '0;
         d_out         <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (init_start_in) begin
                  state       <= ST_INIT;
                  init_val    <= init_value_in;
                  init_cnt    <= '0;
                  r_d_wen_out <= 1'b0;
               end else if (!fifo_empty) begin
                  // Out-of-range addresses are consumed but never strobed.
                  r_d_wen_out   <= ({1'b0, head.addr} < NUM_REGS_X);
                  r_d_waddr_out <= head.addr;
                  d_out         <= head.data;
               end else begin
                  r_d_wen_out <= 1'b0;
               end
            end
            ST_INIT: begin
               r_d_wen_out   <= 1'b1;
               r_d_waddr_out <= init_cnt;
               d_out         <= init_val;
               if (init_cnt == LAST_ADDR) begin
                  state    <= ST_IDLE;
                  init_cnt <= '0;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
